// File: rtl/ypbpr_to_rgb_if.sv
// Pixel-stream bundle for the YPbPr-to-RGB decoder: component pixels and syncs in,
// RGB pixels, aligned syncs and latched-mode status out.
interface ypbpr_to_rgb_if;
    logic        ce_pix;
    logic        ypbpr_en;
    logic        ypbpr_full;
    logic [23:0] din;
    logic        hs_in;
    logic        vs_in;
    logic        de_in;
    logic [23:0] dout;
    logic        hs_out;
    logic        vs_out;
    logic        de_out;
    logic        mode_en;
    logic        mode_full;

    modport master (
        output ce_pix, ypbpr_en, ypbpr_full, din, hs_in, vs_in, de_in,
        input  dout, hs_out, vs_out, de_out, mode_en, mode_full
    );

    modport slave (
        input  ce_pix, ypbpr_en, ypbpr_full, din, hs_in, vs_in, de_in,
        output dout, hs_out, vs_out, de_out, mode_en, mode_full
    );
endinterface

// File: rtl/ypbpr_to_rgb.sv
// Three-stage YPbPr-to-RGB decoder (offset, multiply/sum, round/clamp) with a mode latch
// that only updates on vs rising edges so that a frame is never decoded in mixed modes.
module ypbpr_to_rgb #(
    parameter bit LAT_ALIGN = 1'b1
) (
    input logic           clk_vid,
    input logic           reset,
    ypbpr_to_rgb_if.slave bus
);

    localparam logic signed [19:0] LIM_Y  = 20'sd298;
    localparam logic signed [19:0] LIM_RV = 20'sd409;
    localparam logic signed [19:0] LIM_GV = 20'sd208;
    localparam logic signed [19:0] LIM_GU = 20'sd100;
    localparam logic signed [19:0] LIM_BU = 20'sd516;
    localparam logic signed [19:0] FUL_Y  = 20'sd256;
    localparam logic signed [19:0] FUL_RV = 20'sd359;
    localparam logic signed [19:0] FUL_GV = 20'sd183;
    localparam logic signed [19:0] FUL_GU = 20'sd88;
    localparam logic signed [19:0] FUL_BU = 20'sd454;

    logic modeEn_q, modeFull_q, prevVs_q;
    logic vsRise, effEn, effFull;

    // A vs rise takes effect on the very pixel sampled with it, hence the bypass around the latch.
    assign vsRise  = bus.ce_pix & bus.vs_in & ~prevVs_q;
    assign effEn   = vsRise ? bus.ypbpr_en   : modeEn_q;
    assign effFull = vsRise ? bus.ypbpr_full : modeFull_q;

    always_ff @(posedge clk_vid) begin
        if (reset) begin
            modeEn_q   <= bus.ypbpr_en;
            modeFull_q <= bus.ypbpr_full;
            prevVs_q   <= 1'b0;
        end else if (bus.ce_pix) begin
            prevVs_q <= bus.vs_in;
            if (vsRise) begin
                modeEn_q   <= bus.ypbpr_en;
                modeFull_q <= bus.ypbpr_full;
            end
        end
    end

    assign bus.mode_en   = modeEn_q;
    assign bus.mode_full = modeFull_q;

    logic signed [8:0] s1Yo_d, s1Cb_d, s1Cr_d;
    logic signed [8:0] s1Yo_q, s1Cb_q, s1Cr_q;
    logic              s1En_q, s1Full_q;
    logic [23:0]       s1Raw_q;
    logic [2:0]        s1Sync_q;

    assign s1Yo_d = $signed({1'b0, bus.din[15:8]}) - (effFull ? 9'sd0 : 9'sd16);
    assign s1Cb_d = $signed({1'b0, bus.din[7:0]})   - 9'sd128;
    assign s1Cr_d = $signed({1'b0, bus.din[23:16]}) - 9'sd128;

    always_ff @(posedge clk_vid) begin
        if (reset) begin
            s1Yo_q   <= '0;
            s1Cb_q   <= '0;
            s1Cr_q   <= '0;
            s1En_q   <= 1'b0;
            s1Full_q <= 1'b0;
            s1Raw_q  <= '0;
            s1Sync_q <= '0;
        end else if (bus.ce_pix) begin
            s1Yo_q   <= s1Yo_d;
            s1Cb_q   <= s1Cb_d;
            s1Cr_q   <= s1Cr_d;
            s1En_q   <= effEn;
            s1Full_q <= effFull;
            s1Raw_q  <= bus.din;
            s1Sync_q <= {bus.hs_in, bus.vs_in, bus.de_in};
        end
    end

    logic signed [19:0] yoW, cbW, crW;
    logic signed [19:0] kY, kRv, kGv, kGu, kBu;
    logic signed [19:0] s2R_d, s2G_d, s2B_d;
    logic signed [19:0] s2R_q, s2G_q, s2B_q;
    logic               s2En_q;
    logic [23:0]        s2Raw_q;
    logic [2:0]         s2Sync_q;

    assign yoW = {{11{s1Yo_q[8]}}, s1Yo_q};
    assign cbW = {{11{s1Cb_q[8]}}, s1Cb_q};
    assign crW = {{11{s1Cr_q[8]}}, s1Cr_q};

    assign kY  = s1Full_q ? FUL_Y  : LIM_Y;
    assign kRv = s1Full_q ? FUL_RV : LIM_RV;
    assign kGv = s1Full_q ? FUL_GV : LIM_GV;
    assign kGu = s1Full_q ? FUL_GU : LIM_GU;
    assign kBu = s1Full_q ? FUL_BU : LIM_BU;

    assign s2R_d = kY * yoW + kRv * crW;
    assign s2G_d = kY * yoW - kGv * crW - kGu * cbW;
    assign s2B_d = kY * yoW + kBu * cbW;

    always_ff @(posedge clk_vid) begin
        if (reset) begin
            s2R_q    <= '0;
            s2G_q    <= '0;
            s2B_q    <= '0;
            s2En_q   <= 1'b0;
            s2Raw_q  <= '0;
            s2Sync_q <= '0;
        end else if (bus.ce_pix) begin
            s2R_q    <= s2R_d;
            s2G_q    <= s2G_d;
            s2B_q    <= s2B_d;
            s2En_q   <= s1En_q;
            s2Raw_q  <= s1Raw_q;
            s2Sync_q <= s1Sync_q;
        end
    end

    function automatic logic [7:0] roundClamp(input logic signed [19:0] sum);
        logic signed [19:0] rounded;
        logic signed [11:0] v;
        rounded = sum + 20'sd128;
        v = rounded[19:8];
        if (v < 12'sd0)
            return 8'd0;
        else if (v > 12'sd255)
            return 8'd255;
        else
            return v[7:0];
    endfunction

    logic [23:0] dout_d, dout_q;
    logic [2:0]  syncOut_q;

    // Blanking is always black, including in bypass.
    always_comb begin
        dout_d = s2En_q ? {roundClamp(s2R_q), roundClamp(s2G_q), roundClamp(s2B_q)} : s2Raw_q;
        if (!s2Sync_q[0])
            dout_d = 24'h0;
    end

    always_ff @(posedge clk_vid) begin
        if (reset) begin
            dout_q    <= '0;
            syncOut_q <= '0;
        end else if (bus.ce_pix) begin
            dout_q    <= dout_d;
            syncOut_q <= s2Sync_q;
        end
    end

    assign bus.dout = dout_q;

    generate
        if (LAT_ALIGN) begin : gAligned
            assign bus.hs_out = syncOut_q[2];
            assign bus.vs_out = syncOut_q[1];
            assign bus.de_out = syncOut_q[0];
        end else begin : gPassThrough
            assign bus.hs_out = bus.hs_in;
            assign bus.vs_out = bus.vs_in;
            assign bus.de_out = bus.de_in;
        end
    endgenerate

endmodule

// File: tb/tb_ypbpr_to_rgb.sv
// Scoreboard bench for ypbpr_to_rgb: stimulus pushes expected pixels, a monitor pops and
// compares on every ce_pix edge and checks that outputs hold between ce_pix edges.
module tb_ypbpr_to_rgb;

    logic clk_vid = 1'b0;
    logic reset;

    ypbpr_to_rgb_if bus ();

    ypbpr_to_rgb #(.LAT_ALIGN(1'b1)) dut (
        .clk_vid (clk_vid),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_vid = ~clk_vid;

    typedef struct packed {
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        de;
    } outT;

    outT  expQ[$];
    int   checks = 0;
    int   errors = 0;
    logic tbPrevVs, mEn, mFull;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] refClamp(input int x);
        int v;
        v = (x + 128) >>> 8;
        if (v < 0) return 8'd0;
        if (v > 255) return 8'd255;
        return v[7:0];
    endfunction

    function automatic logic [23:0] refRgb(input logic [23:0] d, input logic en,
                                           input logic full, input logic de);
        int yo, cb, cr, kY, kR, kGr, kGb, kB;
        if (!de) return 24'h0;
        if (!en) return d;
        cb = int'(d[7:0]) - 128;
        cr = int'(d[23:16]) - 128;
        yo = int'(d[15:8]) - (full ? 0 : 16);
        if (full) begin
            kY = 256; kR = 359; kGr = 183; kGb = 88;  kB = 454;
        end else begin
            kY = 298; kR = 409; kGr = 208; kGb = 100; kB = 516;
        end
        return {refClamp(kY * yo + kR * cr),
                refClamp(kY * yo - kGr * cr - kGb * cb),
                refClamp(kY * yo + kB * cb)};
    endfunction

    // Issue one ce_pix pixel at the current negedge and queue what it must produce.
    task automatic applyStimulus(input logic [23:0] d, input logic hs, input logic vs,
                                 input logic de, input logic useModel, input logic [23:0] expHand);
        outT e;
        if (vs && !tbPrevVs) begin
            mEn   = bus.ypbpr_en;
            mFull = bus.ypbpr_full;
        end
        tbPrevVs = vs;
        e.rgb = useModel ? refRgb(d, mEn, mFull, de) : expHand;
        e.hs  = hs;
        e.vs  = vs;
        e.de  = de;
        expQ.push_back(e);
        bus.ce_pix = 1'b1;
        bus.din    = d;
        bus.hs_in  = hs;
        bus.vs_in  = vs;
        bus.de_in  = de;
        @(posedge clk_vid);
        @(negedge clk_vid);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            bus.ce_pix = 1'b0;
            bus.din    = 24'($urandom);
            bus.hs_in  = 1'($urandom);
            bus.vs_in  = 1'($urandom);
            bus.de_in  = 1'($urandom);
            @(posedge clk_vid);
            @(negedge clk_vid);
        end
    endtask

    task automatic checkMode();
        checkOutput("modeEn", 32'(bus.mode_en), 32'(mEn));
        checkOutput("modeFull", 32'(bus.mode_full), 32'(mFull));
    endtask

    task automatic doReset(input logic en, input logic full);
        reset          = 1'b1;
        bus.ypbpr_en   = en;
        bus.ypbpr_full = full;
        bus.ce_pix     = 1'b1;
        bus.din        = 24'($urandom);
        bus.hs_in      = 1'b1;
        bus.vs_in      = 1'b1;
        bus.de_in      = 1'b1;
        @(posedge clk_vid);
        @(negedge clk_vid);
        checkOutput("rstDout", 32'(bus.dout), 32'h0);
        checkOutput("rstSyncs", 32'({bus.hs_out, bus.vs_out, bus.de_out}), 32'h0);
        checkOutput("rstModeEn", 32'(bus.mode_en), 32'(en));
        checkOutput("rstModeFull", 32'(bus.mode_full), 32'(full));
        @(posedge clk_vid);
        @(negedge clk_vid);
        reset    = 1'b0;
        tbPrevVs = 1'b0;
        mEn      = en;
        mFull    = full;
        expQ.delete();
        expQ.push_back('0);
        expQ.push_back('0);
    endtask

    // Monitor: the output register advances only on ce_pix edges outside reset.
    initial begin : monitor
        logic ceS, rstS;
        outT  cur, lastOut, e;
        lastOut = '0;
        forever begin
            @(posedge clk_vid);
            ceS  = bus.ce_pix;
            rstS = reset;
            #1;
            cur = {bus.dout, bus.hs_out, bus.vs_out, bus.de_out};
            if (rstS) begin
                lastOut = cur;
            end else if (ceS) begin
                if (expQ.size() == 0) begin
                    checkOutput("queueUnderflow", 32'(cur), 32'hDEAD_BEEF);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("pipeOut", 32'(cur), 32'(e));
                end
                lastOut = cur;
            end else begin
                checkOutput("holdNoCe", 32'(cur), 32'(lastOut));
            end
        end
    end

    initial begin
        logic [23:0] d;
        reset          = 1'b1;
        bus.ce_pix     = 1'b0;
        bus.ypbpr_en   = 1'b1;
        bus.ypbpr_full = 1'b0;
        bus.din        = '0;
        bus.hs_in      = 1'b0;
        bus.vs_in      = 1'b0;
        bus.de_in      = 1'b0;
        tbPrevVs       = 1'b0;
        mEn            = 1'b1;
        mFull          = 1'b0;
        @(negedge clk_vid);
        doReset(1'b1, 1'b0);

        // Limited-range frame.
        applyStimulus(24'h808080, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000);
        checkMode();
        applyStimulus({8'd128, 8'd235, 8'd128}, 1'b0, 1'b0, 1'b1, 1'b0, 24'hFFFFFF);
        applyStimulus({8'd128, 8'd16,  8'd128}, 1'b0, 1'b0, 1'b1, 1'b0, 24'h000000);
        applyStimulus({8'd128, 8'd126, 8'd128}, 1'b1, 1'b0, 1'b1, 1'b0, 24'h808080);
        applyStimulus({8'd240, 8'd81,  8'd90 }, 1'b0, 1'b0, 1'b1, 1'b0, 24'hFF0000);
        applyStimulus({8'd128, 8'd255, 8'd128}, 1'b0, 1'b0, 1'b1, 1'b0, 24'hFFFFFF);
        applyStimulus({8'd128, 8'd235, 8'd128}, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000);

        // Full range requested mid-frame: still limited until the next vs rise.
        bus.ypbpr_full = 1'b1;
        applyStimulus({8'd128, 8'd128, 8'd128}, 1'b0, 1'b0, 1'b1, 1'b0, 24'h828282);
        checkMode();
        applyStimulus({8'd128, 8'd128, 8'd128}, 1'b0, 1'b1, 1'b1, 1'b0, 24'h808080);
        checkMode();
        applyStimulus({8'd128, 8'd255, 8'd128}, 1'b0, 1'b1, 1'b1, 1'b0, 24'hFFFFFF);
        applyStimulus({8'd128, 8'd0,   8'd128}, 1'b0, 1'b0, 1'b1, 1'b0, 24'h000000);
        applyStimulus({8'd255, 8'd128, 8'd128}, 1'b1, 1'b0, 1'b1, 1'b0, 24'hFF2580);

        // Bypass frame.
        bus.ypbpr_en = 1'b0;
        applyStimulus(24'h123456, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000);
        d = 24'($urandom);
        applyStimulus(d, 1'b0, 1'b1, 1'b1, 1'b0, d);
        checkMode();
        for (int i = 0; i < 8; i++) begin
            d = 24'($urandom);
            applyStimulus(d, 1'($urandom), 1'b0, 1'b1, 1'b0, d);
        end
        applyStimulus(24'($urandom), 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000);

        // Limited decode with ce_pix every 4th clock and a random stream.
        bus.ypbpr_en   = 1'b1;
        bus.ypbpr_full = 1'b0;
        applyStimulus(24'h0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h0);
        idleCycles(3);
        applyStimulus(24'h0, 1'b0, 1'b1, 1'b0, 1'b1, 24'h0);
        idleCycles(3);
        checkMode();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(24'($urandom), 1'($urandom), 1'b0, ($urandom_range(0, 3) != 0), 1'b1, 24'h0);
            idleCycles(3);
        end

        // Reset mid-line with a different request, then bypass pixels right after it.
        applyStimulus(24'($urandom), 1'b0, 1'b0, 1'b1, 1'b1, 24'h0);
        doReset(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            d = 24'($urandom);
            applyStimulus(d, 1'($urandom), 1'b0, 1'b1, 1'b0, d);
        end
        checkMode();
        applyStimulus(24'h0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
        applyStimulus(24'h0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
        bus.ce_pix = 1'b0;
        repeat (3) @(negedge clk_vid);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ypbpr_to_rgb.md
Name: ypbpr_to_rgb

Overview:
- Pipelined YPbPr-to-RGB decoder for the video input path; inverse of the RGB-to-YPbPr output encoder.
- Accepts packed 24-bit component pixels plus syncs and produces 24-bit RGB with syncs and DE delayed to match.
- Decode mode is latched only at vertical sync, so a frame is never decoded in mixed modes.
- Supports limited-range (BT.601, 16..235/240) and full-range input, plus a same-latency bypass.

Parameters:
- LAT_ALIGN, 1, 1 = delay hs/vs/de by the pipeline latency; 0 = pass syncs unregistered (debug only).

Ports:
- clk_vid  in  1  video clock
- reset  in  1  synchronous, active-high
- ce_pix  in  1  pixel clock enable; all pipeline stages advance only when high
- ypbpr_en  in  1  requested mode: 1 = decode, 0 = bypass
- ypbpr_full  in  1  requested range: 1 = full-range input, 0 = limited
- din  in  24  [23:16] Pr, [15:8] Y, [7:0] Pb (unsigned)
- hs_in, vs_in, de_in  in  1 each  syncs/enable aligned to din
- dout  out  24  [23:16] R, [15:8] G, [7:0] B
- hs_out, vs_out, de_out  out  1 each  syncs aligned to dout
- mode_en, mode_full  out  1 each  currently latched mode, for status

Behaviour:
- Reset:
  - All pipeline registers and outputs (dout, hs_out, vs_out, de_out) are cleared to 0.
  - mode_en and mode_full load directly from ypbpr_en and ypbpr_full.
  - The previous-vs register clears to 0.
- Mode latch:
  - On a ce_pix cycle where vs_in = 1 and the previous vs_in sample = 0, mode_en and mode_full load the request inputs.
  - Otherwise they hold; changing the request mid-frame has no effect until the next vs rising edge.
- Pipeline: 3 ce_pix-qualified stages. Data and syncs presented on ce_pix cycle N appear on outputs after the 3rd following ce_pix edge. With ce_pix = 0 everything holds.
- S1 (offsets, 9-bit signed):
  - yo = Y - 16 (limited) or Y (full).
  - cb = Pb - 128, cr = Pr - 128.
  - The latched mode tags travel with the data through the pipeline.
- S2 (multiply/sum, 20-bit signed):
  - Limited: R = 298*yo + 409*cr; G = 298*yo - 208*cr - 100*cb; B = 298*yo + 516*cb.
  - Full: R = 256*yo + 359*cr; G = 256*yo - 183*cr - 88*cb; B = 256*yo + 454*cb.
- S3 (round/clamp):
  - v = (sum + 128) >>> 8 (arithmetic shift).
  - Clamp: v < 0 gives 0, v > 255 gives 255, otherwise v[7:0].
- Bypass (mode_en = 0 in the data's tag): dout = din delayed through the same 3 stages, unchanged bit-for-bit.
- Sync alignment:
  - hs/vs/de pass through the same 3 ce_pix stages, so dout, de_out and syncs stay aligned in every mode.
  - With LAT_ALIGN = 0, syncs are combinational passthrough.
- de handling: dout is forced to 0 at S3 when the data's tagged de is 0 (blanking = black in both modes).
- Simultaneous vs rise and ce_pix: the new mode applies to the pixel sampled in that same cycle.
- Reset mid-frame: the pipeline flushes to zeros; the first valid output appears 3 ce_pix cycles after reset deasserts.

Test Plan:
- Limited, de = 1, din = {Pr 128, Y 235, Pb 128} -> after 3 ce_pix: dout = FFFFFF. Y = 16 -> 000000. Y = 126 -> 808080.
- Limited red, din = {240, 81, 90} -> dout = FF0000 (G and B clamp from negative to 0). Y = 255 with chroma 128 -> FFFFFF (clamp high).
- Full mode latched, {128, 255, 128} -> FFFFFF; {128, 0, 128} -> 000000. Toggle ypbpr_full mid-frame -> output range unchanged until the next vs_in rise, then switches.
- Bypass (ypbpr_en = 0): random din with de = 1 -> dout equals din exactly 3 ce_pix later. hs/vs/de patterns stay aligned in all modes.
- ce_pix = 1 every 4th clk_vid with a random pixel stream -> outputs change only on ce_pix edges, latency 3 ce_pix, no drops or duplicates versus the reference model.
- Assert reset mid-line -> next cycle all outputs 0 and mode regs equal the request inputs; de = 0 pixels always give dout = 0.
